// File: rtl/ladybird_input_conditioner.sv
// Input conditioner for ladybird_gpio: synchronizer, per-bit debounce,
// and registered single-cycle rise/fall pulses on the debounced level.
module ladybird_input_conditioner #(
    parameter int                 N_INPUT         = 8,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 50000,
    parameter logic [N_INPUT-1:0] RESET_LEVEL     = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_INPUT-1:0] raw_i,
    output logic [N_INPUT-1:0] level_o,
    output logic [N_INPUT-1:0] rise_o,
    output logic [N_INPUT-1:0] fall_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N_INPUT-1:0] sync_q [SYNC_STAGES];
    logic [N_INPUT-1:0] synced;

    logic [N_INPUT-1:0] level_q, level_d;
    logic [N_INPUT-1:0] rise_q, rise_d;
    logic [N_INPUT-1:0] fall_q, fall_d;
    logic [CNT_W-1:0]   cnt_q [N_INPUT];
    logic [CNT_W-1:0]   cnt_d [N_INPUT];

    assign synced = sync_q[SYNC_STAGES-1];

    // cnt==0 is STABLE, cnt>0 is COUNTING; agreement or terminal count returns to STABLE
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N_INPUT; i++) begin
            cnt_d[i] = '0;
            if (synced[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = synced[i];
                    rise_d[i]  = synced[i];
                    fall_d[i]  = !synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_LEVEL;
            end
            for (int i = 0; i < N_INPUT; i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= RESET_LEVEL;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            sync_q[0] <= raw_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            for (int i = 0; i < N_INPUT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: tb/tb_ladybird_input_conditioner.sv
// Directed bench for ladybird_input_conditioner with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, N_INPUT=8, RESET_LEVEL=0.
module tb_ladybird_input_conditioner;

    logic       clk;
    logic       rst;
    logic [7:0] raw_i;
    logic [7:0] level_o;
    logic [7:0] rise_o;
    logic [7:0] fall_o;

    int checks;
    int errors;

    ladybird_input_conditioner #(
        .N_INPUT         (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_LEVEL     (8'h00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (raw_i),
        .level_o (level_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one posedge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        raw_i = 8'h00;
        rst   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        raw_i = 8'hFF;
        rst   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (level_o !== 8'h00 || rise_o !== 8'h00 || fall_o !== 8'h00) begin
                $display("FAIL reset_hold[%0d]: level=%h rise=%h fall=%h, required 00/00/00",
                         k, level_o, rise_o, fall_o);
                errors++;
            end
        end
        rst = 1'b0;
        // Edge 0 is the first posedge with rst low; level updates at edge 5.
        for (int k = 0; k <= 6; k++) begin
            logic [7:0] exp_lvl;
            logic [7:0] exp_rise;
            tick();
            exp_lvl  = (k >= 5) ? 8'hFF : 8'h00;
            exp_rise = (k == 5) ? 8'hFF : 8'h00;
            checks++;
            if (level_o !== exp_lvl || rise_o !== exp_rise || fall_o !== 8'h00) begin
                $display("FAIL reset_release[%0d]: level=%h rise=%h fall=%h, required %h/%h/00",
                         k, level_o, rise_o, fall_o, exp_lvl, exp_rise);
                errors++;
            end
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        raw_i = 8'h01;
        for (int k = 0; k <= 6; k++) begin
            logic [7:0] exp_lvl;
            logic [7:0] exp_rise;
            tick();
            exp_lvl  = (k >= 5) ? 8'h01 : 8'h00;
            exp_rise = (k == 5) ? 8'h01 : 8'h00;
            checks++;
            if (level_o !== exp_lvl || rise_o !== exp_rise || fall_o !== 8'h00) begin
                $display("FAIL press[%0d]: level=%h rise=%h fall=%h, required %h/%h/00",
                         k, level_o, rise_o, fall_o, exp_lvl, exp_rise);
                errors++;
            end
        end
        raw_i = 8'h00;
        for (int k = 0; k <= 6; k++) begin
            logic [7:0] exp_lvl;
            logic [7:0] exp_fall;
            tick();
            exp_lvl  = (k >= 5) ? 8'h00 : 8'h01;
            exp_fall = (k == 5) ? 8'h01 : 8'h00;
            checks++;
            if (level_o !== exp_lvl || fall_o !== exp_fall || rise_o !== 8'h00) begin
                $display("FAIL release[%0d]: level=%h rise=%h fall=%h, required %h/00/%h",
                         k, level_o, rise_o, fall_o, exp_lvl, exp_fall);
                errors++;
            end
        end
    endtask

    task automatic test_glitch();
        raw_i = 8'h02;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 2) raw_i = 8'h00;
            checks++;
            if (level_o !== 8'h00 || rise_o !== 8'h00 || fall_o !== 8'h00) begin
                $display("FAIL glitch[%0d]: level=%h rise=%h fall=%h, required 00/00/00",
                         k, level_o, rise_o, fall_o);
                errors++;
            end
        end
    endtask

    task automatic test_bounce();
        // Edges 0..9 sample 1,0,1,0,...; from edge 10 raw holds 1.
        for (int k = 0; k <= 16; k++) begin
            logic [7:0] exp_lvl;
            logic [7:0] exp_rise;
            if (k < 10) raw_i = (k % 2 == 0) ? 8'h04 : 8'h00;
            else        raw_i = 8'h04;
            tick();
            exp_lvl  = (k >= 15) ? 8'h04 : 8'h00;
            exp_rise = (k == 15) ? 8'h04 : 8'h00;
            checks++;
            if (level_o !== exp_lvl || rise_o !== exp_rise || fall_o !== 8'h00) begin
                $display("FAIL bounce[%0d]: level=%h rise=%h fall=%h, required %h/%h/00",
                         k, level_o, rise_o, fall_o, exp_lvl, exp_rise);
                errors++;
            end
        end
    endtask

    task automatic test_parallel();
        do_reset();
        raw_i = 8'hA5;
        for (int k = 0; k <= 6; k++) begin
            logic [7:0] exp_lvl;
            logic [7:0] exp_rise;
            tick();
            exp_lvl  = (k >= 5) ? 8'hA5 : 8'h00;
            exp_rise = (k == 5) ? 8'hA5 : 8'h00;
            checks++;
            if (level_o !== exp_lvl || rise_o !== exp_rise || fall_o !== 8'h00) begin
                $display("FAIL parallel_rise[%0d]: level=%h rise=%h fall=%h, required %h/%h/00",
                         k, level_o, rise_o, fall_o, exp_lvl, exp_rise);
                errors++;
            end
        end
        // Swap patterns: A5 bits fall while 5A bits rise in the same cycle.
        raw_i = 8'h5A;
        for (int k = 0; k <= 6; k++) begin
            logic [7:0] exp_lvl;
            logic [7:0] exp_rise;
            logic [7:0] exp_fall;
            tick();
            exp_lvl  = (k >= 5) ? 8'h5A : 8'hA5;
            exp_rise = (k == 5) ? 8'h5A : 8'h00;
            exp_fall = (k == 5) ? 8'hA5 : 8'h00;
            checks++;
            if (level_o !== exp_lvl || rise_o !== exp_rise || fall_o !== exp_fall) begin
                $display("FAIL parallel_swap[%0d]: level=%h rise=%h fall=%h, required %h/%h/%h",
                         k, level_o, rise_o, fall_o, exp_lvl, exp_rise, exp_fall);
                errors++;
            end
        end
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        raw_i = 8'h08;
        for (int k = 0; k <= 10; k++) begin
            logic [7:0] exp_lvl;
            logic [7:0] exp_rise;
            rst = (k == 3);
            tick();
            exp_lvl  = (k >= 9) ? 8'h08 : 8'h00;
            exp_rise = (k == 9) ? 8'h08 : 8'h00;
            checks++;
            if (level_o !== exp_lvl || rise_o !== exp_rise || fall_o !== 8'h00) begin
                $display("FAIL reset_mid[%0d]: level=%h rise=%h fall=%h, required %h/%h/00",
                         k, level_o, rise_o, fall_o, exp_lvl, exp_rise);
                errors++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        raw_i  = 8'h00;
        tick();
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_parallel();
        test_reset_mid_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
